// File: rtl/ber_pkg.sv
// ber_pkg: shared state encoding and constants for the BER sweep controller
package ber_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DRAIN, REPORT} sweep_state_t;
  localparam logic [31:0] IDX_IDLE = 32'hFFFF_FFFF;
  localparam int CNT_W = 64;
endpackage

// File: rtl/ber_sweep_ctrl.sv
// ber_sweep_ctrl: per SNR point loads the probability table, runs the datapath to a stop criterion, drains and reports counters
module ber_sweep_ctrl
  import ber_pkg::*;
#(
  parameter int N_POINTS  = 8,
  parameter int TBL_DEPTH = 64,
  parameter int PROB_W    = 64,
  parameter int CNT_W     = ber_pkg::CNT_W,
  parameter int DRAIN_CYC = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [CNT_W-1:0]                      cfg_min_bits,
  input  logic [CNT_W-1:0]                      cfg_max_ferr,
  input  logic [31:0]                           cfg_max_cycles,
  input  logic [3:0]                            cfg_n_interleave,
  output logic [$clog2(N_POINTS*TBL_DEPTH)-1:0] tbl_addr,
  input  logic [PROB_W-1:0]                     tbl_data,
  output logic                                  sys_en,
  output logic                                  sys_rstn,
  output logic [31:0]                           probability_idx,
  output logic [PROB_W-1:0]                     probability_in,
  output logic [3:0]                            n_interleave,
  input  logic [CNT_W-1:0]                      total_bits,
  input  logic [CNT_W-1:0]                      total_bit_errors_pre,
  input  logic [CNT_W-1:0]                      total_bit_errors_post,
  input  logic [CNT_W-1:0]                      total_frames,
  input  logic [CNT_W-1:0]                      total_frame_errors,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [7:0]                            res_point,
  output logic                                  res_timeout,
  output logic [CNT_W-1:0]                      res_bits,
  output logic [CNT_W-1:0]                      res_pre,
  output logic [CNT_W-1:0]                      res_post,
  output logic [CNT_W-1:0]                      res_frames,
  output logic [CNT_W-1:0]                      res_ferr,
  output logic                                  busy,
  output logic                                  done
);
  localparam int AW = $clog2(N_POINTS*TBL_DEPTH);
  localparam int KW = $clog2(TBL_DEPTH+1);
  localparam int DW = $clog2(DRAIN_CYC+1);
  sweep_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [31:0] cyc_q, cyc_d, max_cyc_q;
  logic [7:0] point_q, point_d, r_point_q;
  logic [CNT_W-1:0] min_bits_q, max_ferr_q;
  logic [CNT_W-1:0] r_bits_q, r_pre_q, r_post_q, r_frames_q, r_ferr_q;
  logic [3:0] n_int_q;
  logic r_to_q, done_q;
  logic clr, wr, last, hs, bits_hit, ferr_hit, to_hit, stop, snap;
  // qualifiers shared by the FSM and the datapath registers; abort outside IDLE behaves like a reset
  always_comb begin
    clr = rst || (abort && state_q != IDLE);
    wr = state_q == LOAD && k_q != '0;
    last = point_q == 8'(N_POINTS-1);
    hs = state_q == REPORT && res_ready;
    bits_hit = total_bits >= min_bits_q;
    ferr_hit = max_ferr_q != '0 && total_frame_errors >= max_ferr_q;
    to_hit = max_cyc_q != '0 && cyc_q == max_cyc_q - 32'd1;
    stop = bits_hit || ferr_hit || to_hit;
    snap = state_q == DRAIN && drain_q == DW'(DRAIN_CYC-1);
  end
  // sweep sequencer next state; LOAD spends one extra cycle so the last table word can be written
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    drain_d = drain_q;
    cyc_d = cyc_q;
    point_d = point_q;
    case (state_q)
      IDLE: begin
        k_d = '0;
        point_d = '0;
        state_d = start ? LOAD : IDLE;
      end
      LOAD: begin
        k_d = k_q + 1'b1;
        state_d = k_q == KW'(TBL_DEPTH) ? ARM : LOAD;
      end
      ARM: begin
        cyc_d = '0;
        state_d = RUN;
      end
      RUN: begin
        cyc_d = cyc_q + 32'd1;
        drain_d = '0;
        state_d = stop ? DRAIN : RUN;
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        state_d = snap ? REPORT : DRAIN;
      end
      REPORT: if (res_ready) begin
        k_d = '0;
        point_d = last ? point_q : point_q + 8'd1;
        state_d = last ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, config latches at start and the result snapshot taken on the last drain cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      k_q <= '0;
      drain_q <= '0;
      cyc_q <= '0;
      point_q <= '0;
      min_bits_q <= '0;
      max_ferr_q <= '0;
      max_cyc_q <= '0;
      n_int_q <= '0;
      r_point_q <= '0;
      r_to_q <= 1'b0;
      r_bits_q <= '0;
      r_pre_q <= '0;
      r_post_q <= '0;
      r_frames_q <= '0;
      r_ferr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      drain_q <= drain_d;
      cyc_q <= cyc_d;
      point_q <= point_d;
      done_q <= hs && last;
      if (state_q == IDLE && start) begin
        min_bits_q <= cfg_min_bits;
        max_ferr_q <= cfg_max_ferr;
        max_cyc_q <= cfg_max_cycles;
        n_int_q <= cfg_n_interleave;
      end
      if (state_q == RUN && stop) r_to_q <= to_hit && !bits_hit && !ferr_hit;
      if (snap) begin
        r_point_q <= point_q;
        r_bits_q <= total_bits;
        r_pre_q <= total_bit_errors_pre;
        r_post_q <= total_bit_errors_post;
        r_frames_q <= total_frames;
        r_ferr_q <= total_frame_errors;
      end
    end
  end
  assign tbl_addr = (state_q == LOAD && k_q < KW'(TBL_DEPTH)) ? AW'(point_q) * AW'(TBL_DEPTH) + AW'(k_q) : '0;
  assign probability_idx = wr ? 32'(k_q - 1'b1) : IDX_IDLE;
  assign probability_in = wr ? tbl_data : '0;
  assign n_interleave = n_int_q;
  assign sys_en = state_q == RUN;
  assign sys_rstn = state_q != IDLE && state_q != LOAD;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign res_valid = state_q == REPORT;
  assign res_point = r_point_q;
  assign res_timeout = r_to_q;
  assign res_bits = r_bits_q;
  assign res_pre = r_pre_q;
  assign res_post = r_post_q;
  assign res_frames = r_frames_q;
  assign res_ferr = r_ferr_q;
endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// tb_ber_sweep_ctrl: randomized sweeps checked against a transaction-level model of the sweep sequencer
module tb_ber_sweep_ctrl;
  localparam int NP = 2, TD = 64, PW = 64, CW = 64, DC = 16;
  localparam int AW = $clog2(NP*TD);
  logic clk = 0, rst = 1, start = 0, abort = 0, res_ready = 0;
  logic [CW-1:0] cfg_min_bits = '0, cfg_max_ferr = '0;
  logic [31:0] cfg_max_cycles = '0;
  logic [3:0] cfg_n_interleave = '0;
  logic [AW-1:0] tbl_addr;
  logic [PW-1:0] tbl_data = '0;
  logic sys_en, sys_rstn, res_valid, res_timeout, busy, done;
  logic [31:0] probability_idx;
  logic [PW-1:0] probability_in;
  logic [3:0] n_interleave;
  logic [CW-1:0] total_bits, total_bit_errors_pre, total_bit_errors_post, total_frames, total_frame_errors;
  logic [7:0] res_point;
  logic [CW-1:0] res_bits, res_pre, res_post, res_frames, res_ferr;
  int vec = 0, errs = 0;
  int unsigned ncyc = 0, bpc = 1, ferr_m = 1;
  int en_cnt = 0, done_cnt = 0, rv_cnt = 0;
  int unsigned widx[$];
  logic [PW-1:0] wdat[$];

  ber_sweep_ctrl #(.N_POINTS(NP), .TBL_DEPTH(TD), .PROB_W(PW), .CNT_W(CW), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_min_bits(cfg_min_bits), .cfg_max_ferr(cfg_max_ferr), .cfg_max_cycles(cfg_max_cycles),
    .cfg_n_interleave(cfg_n_interleave), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .sys_en(sys_en), .sys_rstn(sys_rstn), .probability_idx(probability_idx), .probability_in(probability_in),
    .n_interleave(n_interleave), .total_bits(total_bits), .total_bit_errors_pre(total_bit_errors_pre),
    .total_bit_errors_post(total_bit_errors_post), .total_frames(total_frames), .total_frame_errors(total_frame_errors),
    .res_valid(res_valid), .res_ready(res_ready), .res_point(res_point), .res_timeout(res_timeout),
    .res_bits(res_bits), .res_pre(res_pre), .res_post(res_post), .res_frames(res_frames), .res_ferr(res_ferr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // table memory: word at point p, entry i is {p, i}, one-cycle read latency
  always @(posedge clk) tbl_data <= {32'(tbl_addr / TD), 32'(tbl_addr % TD)};

  // datapath: every enabled cycle adds bpc bits, 3 pre errors, 1 post error, 1 frame; a frame error every ferr_m frames
  always @(negedge clk) ncyc <= !sys_rstn ? 0 : ncyc + (sys_en ? 1 : 0);
  assign total_bits = CW'(bpc) * CW'(ncyc);
  assign total_bit_errors_pre = CW'(3 * ncyc);
  assign total_bit_errors_post = CW'(ncyc);
  assign total_frames = CW'(ncyc);
  assign total_frame_errors = CW'(ncyc / ferr_m);

  // observer of enable cycles, table writes, results and done pulses
  always @(negedge clk) begin
    if (sys_en === 1'b1) en_cnt++;
    if (done === 1'b1) done_cnt++;
    if (res_valid === 1'b1) rv_cnt++;
    if (probability_idx !== 32'hFFFF_FFFF) begin
      widx.push_back(probability_idx);
      wdat.push_back(probability_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // number of enabled RUN cycles until the first stop criterion, and whether only the timeout fired
  function automatic int unsigned run_len(input longint unsigned minb, input longint unsigned maxf,
                                          input int unsigned maxc, input int unsigned b, input int unsigned m,
                                          output bit to);
    bit hb, hf, hc;
    to = 0;
    for (int unsigned l = 1; l < 100000; l++) begin
      hb = 64'(b) * 64'(l) >= minb;
      hf = maxf != 0 && 64'(l / m) >= maxf;
      hc = maxc != 0 && l == maxc;
      if (hb || hf || hc) begin
        to = hc && !hb && !hf;
        return l;
      end
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    vec++;
    if ({sys_en, sys_rstn, busy, done, res_valid, res_timeout} !== 6'b0) begin
      errs++;
      $display("FAIL reset_ctrl got %b required 000000", {sys_en, sys_rstn, busy, done, res_valid, res_timeout});
    end
    vec++;
    if (probability_idx !== 32'hFFFF_FFFF || probability_in !== '0 || n_interleave !== '0 || tbl_addr !== '0) begin
      errs++;
      $display("FAIL reset_load idx=%h in=%h ni=%h addr=%h required ffffffff/0/0/0", probability_idx, probability_in, n_interleave, tbl_addr);
    end
    vec++;
    if (res_point !== '0 || {res_bits, res_pre, res_post, res_frames, res_ferr} !== '0) begin
      errs++;
      $display("FAIL reset_res point=%h bits=%h pre=%h post=%h frames=%h ferr=%h required all 0", res_point, res_bits, res_pre, res_post, res_frames, res_ferr);
    end
  endtask

  task automatic test_sweep(input string nm, input longint unsigned minb, input longint unsigned maxf,
                            input int unsigned maxc, input int unsigned b, input int unsigned m, input int hold);
    bit to, ok;
    int unsigned len;
    int bad;
    logic [3:0] ni;
    logic [5*CW-1:0] snapv, expv;
    len = run_len(minb, maxf, maxc, b, m, to);
    bpc = b;
    ferr_m = m;
    ni = 4'($urandom_range(0, 15));
    cfg_min_bits = minb;
    cfg_max_ferr = maxf;
    cfg_max_cycles = maxc;
    cfg_n_interleave = ni;
    done_cnt = 0;
    start = 1;
    tick();
    start = 0;
    cfg_n_interleave = ~ni;
    vec++;
    if (n_interleave !== ni) begin
      errs++;
      $display("FAIL %s_ninterleave got %h required %h", nm, n_interleave, ni);
    end
    for (int p = 0; p < NP; p++) begin
      widx.delete();
      wdat.delete();
      en_cnt = 0;
      ok = 0;
      for (int i = 0; i < 4000 && !ok; i++) if (res_valid === 1'b1) ok = 1; else tick();
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL %s_valid_p%0d res_valid stayed low, required high within 4000 cycles", nm, p);
        return;
      end
      bad = 0;
      foreach (widx[i]) if (widx[i] != i || wdat[i] !== {32'(p), 32'(i)}) bad++;
      vec++;
      if (widx.size() != TD || bad != 0) begin
        errs++;
        $display("FAIL %s_load_p%0d got %0d writes with %0d wrong, required %0d ordered writes of {p,idx}", nm, p, widx.size(), bad, TD);
      end
      vec++;
      if (en_cnt != int'(len)) begin
        errs++;
        $display("FAIL %s_run_len_p%0d got %0d enabled cycles required %0d", nm, p, en_cnt, len);
      end
      vec++;
      if (res_point !== 8'(p) || res_timeout !== to) begin
        errs++;
        $display("FAIL %s_point_p%0d got point=%0d timeout=%b required point=%0d timeout=%b", nm, p, res_point, res_timeout, p, to);
      end
      expv = {CW'(b) * CW'(len), CW'(3 * len), CW'(len), CW'(len), CW'(len / m)};
      snapv = {res_bits, res_pre, res_post, res_frames, res_ferr};
      vec++;
      if (snapv !== expv) begin
        errs++;
        $display("FAIL %s_counts_p%0d got %h required %h", nm, p, snapv, expv);
      end
      bad = 0;
      repeat (hold) begin
        tick();
        if ({res_bits, res_pre, res_post, res_frames, res_ferr} !== snapv || res_valid !== 1'b1 || sys_rstn !== 1'b1 || sys_en !== 1'b0) bad++;
      end
      vec++;
      if (bad != 0) begin
        errs++;
        $display("FAIL %s_hold_p%0d got %0d unstable cycles of %0d required 0", nm, p, bad, hold);
      end
      res_ready = 1;
      tick();
      res_ready = 0;
      if (p < NP - 1) begin
        vec++;
        if (res_valid !== 1'b0 || sys_rstn !== 1'b0 || busy !== 1'b1 || tbl_addr !== AW'((p + 1) * TD)) begin
          errs++;
          $display("FAIL %s_next_p%0d got valid=%b rstn=%b busy=%b addr=%0d required 0/0/1/%0d", nm, p, res_valid, sys_rstn, busy, tbl_addr, (p + 1) * TD);
        end
      end else begin
        vec++;
        if (res_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
          errs++;
          $display("FAIL %s_last got valid=%b done=%b busy=%b required 0/1/0", nm, res_valid, done, busy);
        end
      end
    end
    tick();
    vec++;
    if (done !== 1'b0 || done_cnt != 1) begin
      errs++;
      $display("FAIL %s_done got done=%b pulses=%0d required 0 and 1 pulse", nm, done, done_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++)
      test_sweep("rand", longint'($urandom_range(100, 2000)), longint'($urandom_range(0, 8)),
                 $urandom_range(0, 60), $urandom_range(1, 50), $urandom_range(1, 5), int'($urandom_range(0, 4)));
  endtask

  task automatic test_abort_load();
    bpc = 1;
    ferr_m = 1;
    cfg_min_bits = '1;
    cfg_max_ferr = '0;
    cfg_max_cycles = '0;
    rv_cnt = 0;
    done_cnt = 0;
    start = 1;
    tick();
    start = 0;
    repeat (30) tick();
    vec++;
    if (tbl_addr !== AW'(30) || probability_idx !== 32'd29) begin
      errs++;
      $display("FAIL abort_load_k30 got addr=%0d idx=%0d required 30/29", tbl_addr, probability_idx);
    end
    abort = 1;
    tick();
    abort = 0;
    vec++;
    if (busy !== 1'b0 || sys_en !== 1'b0 || sys_rstn !== 1'b0 || res_valid !== 1'b0 || probability_idx !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL abort_load_idle got busy=%b en=%b rstn=%b valid=%b idx=%h required 0/0/0/0/ffffffff", busy, sys_en, sys_rstn, res_valid, probability_idx);
    end
    repeat (4) tick();
    start = 1;
    tick();
    start = 0;
    vec++;
    if (busy !== 1'b1 || tbl_addr !== '0 || probability_idx !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL restart_k0 got busy=%b addr=%0d idx=%h required 1/0/ffffffff", busy, tbl_addr, probability_idx);
    end
    tick();
    tick();
    vec++;
    if (probability_idx !== 32'd1 || probability_in !== {32'd0, 32'd1} || tbl_addr !== AW'(2)) begin
      errs++;
      $display("FAIL restart_k2 got idx=%0d data=%h addr=%0d required 1/%h/2", probability_idx, probability_in, tbl_addr, {32'd0, 32'd1});
    end
    abort = 1;
    tick();
    abort = 0;
    vec++;
    if (rv_cnt != 0 || done_cnt != 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_load_quiet got results=%0d done=%0d busy=%b required 0/0/0", rv_cnt, done_cnt, busy);
    end
  endtask

  task automatic test_abort_run();
    bit ok;
    bpc = 1;
    ferr_m = 1;
    cfg_min_bits = '1;
    cfg_max_ferr = '0;
    cfg_max_cycles = '0;
    rv_cnt = 0;
    done_cnt = 0;
    start = 1;
    tick();
    start = 0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) if (sys_en === 1'b1) ok = 1; else tick();
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL abort_run_enter sys_en stayed low, required high within 200 cycles");
    end
    repeat (5) tick();
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    vec++;
    if (busy !== 1'b0 || sys_en !== 1'b0 || sys_rstn !== 1'b0 || probability_idx !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL abort_run_wins got busy=%b en=%b rstn=%b idx=%h required 0/0/0/ffffffff", busy, sys_en, sys_rstn, probability_idx);
    end
    tick();
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_run_stays got busy=%b required 0", busy);
    end
    start = 1;
    tick();
    start = 0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) if (sys_en === 1'b1) ok = 1; else tick();
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL rst_run_enter sys_en stayed low, required high within 200 cycles");
    end
    repeat (3) tick();
    test_reset();
    vec++;
    if (rv_cnt != 0 || done_cnt != 0) begin
      errs++;
      $display("FAIL abort_run_quiet got results=%0d done=%0d required 0/0", rv_cnt, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sweep("bits", 1000, 0, 0, 100, 7, 2);
    test_sweep("ferr", 64'hFFFF_FFFF_FFFF, 5, 0, 1, 3, 1);
    test_sweep("timeout", 64'hFFFF_FFFF_FFFF_FFFF, 0, 20, 1, 1, 50);
    test_sweep("tie", 1000, 0, 10, 100, 1, 0);
    test_random();
    test_abort_load();
    test_abort_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
